// File: rtl/io_pulse_train_ctrl.sv
// Multi-channel pulse-train generator: each channel arms, fires, waits D cycles,
// then emits N pulses of width W separated by G-cycle gaps; hard_stop aborts all.
module io_pulse_train_ctrl #(
  parameter int NCH   = 8,
  parameter int CNT_W = 32,
  parameter int REP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         rest_level,
  input  logic [NCH-1:0]         chan_en,
  input  logic                   arm,
  input  logic                   fire,
  input  logic [NCH*CNT_W-1:0]   delay_bus,
  input  logic [NCH*CNT_W-1:0]   width_bus,
  input  logic [CNT_W-1:0]       gap,
  input  logic [REP_W-1:0]       npulse,
  input  logic                   hard_stop,
  output logic [NCH-1:0]         out_state,
  output logic [NCH-1:0]         chan_done,
  output logic                   all_done,
  output logic                   busy,
  output logic                   aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_ACTIVE, S_GAP, S_DONE
  } state_t;

  state_t             r_state    [NCH];
  state_t             w_state_nxt[NCH];
  logic [CNT_W-1:0]   r_cnt      [NCH];
  logic [CNT_W-1:0]   w_cnt_nxt  [NCH];
  logic [CNT_W-1:0]   r_w        [NCH];
  logic [CNT_W-1:0]   w_w_nxt    [NCH];
  logic [CNT_W-1:0]   r_g        [NCH];
  logic [CNT_W-1:0]   w_g_nxt    [NCH];
  logic [REP_W-1:0]   r_left     [NCH];
  logic [REP_W-1:0]   w_left_nxt [NCH];

  logic [NCH-1:0]     w_out_nxt;
  logic [NCH-1:0]     w_done_nxt;
  logic               w_all_done_nxt;
  logic               w_busy_nxt;
  logic               w_aborted_nxt;

  // State and counter registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_left[i]  <= '0;
      end else begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_left[i]  <= w_left_nxt[i];
      end
      r_w[i] <= w_w_nxt[i];
      r_g[i] <= w_g_nxt[i];
    end
  end

  // Next-state logic; timing counters end on reaching 1 so ACTIVE/GAP last exactly W/G cycles
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_left_nxt[i]  = r_left[i];
      w_w_nxt[i]     = r_w[i];
      w_g_nxt[i]     = r_g[i];
      if (hard_stop) begin
        w_state_nxt[i] = S_IDLE;
        w_cnt_nxt[i]   = '0;
        w_left_nxt[i]  = '0;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            if (arm && chan_en[i]) w_state_nxt[i] = S_ARMED;
          end
          S_ARMED: begin
            w_cnt_nxt[i]  = delay_bus[i*CNT_W +: CNT_W];
            w_w_nxt[i]    = width_bus[i*CNT_W +: CNT_W];
            w_g_nxt[i]    = gap;
            w_left_nxt[i] = (npulse == '0) ? REP_W'(1) : npulse;
            if (!arm)      w_state_nxt[i] = S_IDLE;
            else if (fire) w_state_nxt[i] = S_DELAY;
          end
          S_DELAY: begin
            if (r_cnt[i] == '0) begin
              if (r_w[i] == '0) begin
                w_state_nxt[i] = S_DONE;
              end else begin
                w_state_nxt[i] = S_ACTIVE;
                w_cnt_nxt[i]   = r_w[i];
              end
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          S_ACTIVE: begin
            if (r_cnt[i] <= CNT_W'(1)) begin
              if (r_left[i] != '0) w_left_nxt[i] = r_left[i] - REP_W'(1);
              if (r_left[i] <= REP_W'(1)) begin
                w_state_nxt[i] = S_DONE;
                w_cnt_nxt[i]   = '0;
              end else if (r_g[i] == '0) begin
                w_cnt_nxt[i]   = r_w[i];
              end else begin
                w_state_nxt[i] = S_GAP;
                w_cnt_nxt[i]   = r_g[i];
              end
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          S_GAP: begin
            if (r_cnt[i] <= CNT_W'(1)) begin
              w_state_nxt[i] = S_ACTIVE;
              w_cnt_nxt[i]   = r_w[i];
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          S_DONE: begin
            if (!arm) w_state_nxt[i] = S_IDLE;
          end
          default: w_state_nxt[i] = S_IDLE;
        endcase
      end
    end
  end

  // Outputs derived from next-state so they line up with the state they describe
  always_comb begin
    w_out_nxt     = rest_level;
    w_done_nxt    = '0;
    w_busy_nxt    = 1'b0;
    w_aborted_nxt = aborted;
    for (int i = 0; i < NCH; i++) begin
      if (w_state_nxt[i] == S_ACTIVE) w_out_nxt[i] = ~rest_level[i];
      if (w_state_nxt[i] == S_DONE)   w_done_nxt[i] = 1'b1;
      if (w_state_nxt[i] == S_DELAY || w_state_nxt[i] == S_ACTIVE ||
          w_state_nxt[i] == S_GAP)
        w_busy_nxt = 1'b1;
      if (!hard_stop && r_state[i] == S_IDLE && w_state_nxt[i] == S_ARMED)
        w_aborted_nxt = 1'b0;
    end
    if (hard_stop) begin
      for (int i = 0; i < NCH; i++) begin
        if (r_state[i] != S_IDLE) w_aborted_nxt = 1'b1;
      end
    end
    w_all_done_nxt = (chan_en != '0) && (&(w_done_nxt | ~chan_en));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_state <= rest_level;
      chan_done <= '0;
      all_done  <= 1'b0;
      busy      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      out_state <= w_out_nxt;
      chan_done <= w_done_nxt;
      all_done  <= w_all_done_nxt;
      busy      <= w_busy_nxt;
      aborted   <= w_aborted_nxt;
    end
  end

endmodule

// File: tb/tb_io_pulse_train_ctrl.sv
// Directed bench for io_pulse_train_ctrl: one task per scenario, expectations
// hand-derived from edge k, the edge at which fire is sampled in ARMED.
module tb_io_pulse_train_ctrl;
  localparam int NCH   = 8;
  localparam int CNT_W = 32;
  localparam int REP_W = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       rest_level;
  logic [NCH-1:0]       chan_en;
  logic                 arm;
  logic                 fire;
  logic [NCH*CNT_W-1:0] delay_bus;
  logic [NCH*CNT_W-1:0] width_bus;
  logic [CNT_W-1:0]     gap;
  logic [REP_W-1:0]     npulse;
  logic                 hard_stop;
  logic [NCH-1:0]       out_state;
  logic [NCH-1:0]       chan_done;
  logic                 all_done;
  logic                 busy;
  logic                 aborted;

  int total = 0;
  int bad   = 0;

  io_pulse_train_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .rest_level(rest_level), .chan_en(chan_en),
    .arm(arm), .fire(fire), .delay_bus(delay_bus), .width_bus(width_bus),
    .gap(gap), .npulse(npulse), .hard_stop(hard_stop), .out_state(out_state),
    .chan_done(chan_done), .all_done(all_done), .busy(busy), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] w);
    delay_bus[ch*CNT_W +: CNT_W] = d;
    width_bus[ch*CNT_W +: CNT_W] = w;
  endtask

  // Arms at one edge, fire sampled at the next (edge k); returns just after edge k
  task automatic arm_and_fire();
    arm = 1'b1;
    tick();
    fire = 1'b1;
    tick();
    fire = 1'b0;
  endtask

  task automatic cleanup();
    arm  = 1'b0;
    fire = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; rest_level = 8'hA5; chan_en = '0; arm = 0; fire = 0;
    delay_bus = '0; width_bus = '0; gap = '0; npulse = '0; hard_stop = 0;
    tick(); tick(); tick();
    total++; if (out_state !== 8'hA5) begin bad++; $display("FAIL reset out_state got=%h exp=a5", out_state); end
    total++; if (chan_done !== 8'h00) begin bad++; $display("FAIL reset chan_done got=%h exp=00", chan_done); end
    total++; if (all_done !== 1'b0) begin bad++; $display("FAIL reset all_done got=%b exp=0", all_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL reset aborted got=%b exp=0", aborted); end
    rst = 1'b1; rest_level = 8'h00;
    tick();
    total++; if (out_state !== 8'h00) begin bad++; $display("FAIL rest_follow out_state got=%h exp=00", out_state); end
  endtask

  task automatic test_single_pulse();
    logic e_out, e_done, e_busy;
    chan_en = 8'h01; rest_level = 8'h00; npulse = 8'd1; gap = 32'd0;
    set_ch(0, 32'd3, 32'd5);
    arm_and_fire();
    for (int j = 1; j <= 10; j++) begin
      tick();
      e_out  = (j >= 4 && j <= 8);
      e_done = (j >= 9);
      e_busy = (j <= 8);
      total++; if (out_state[0] !== e_out) begin bad++; $display("FAIL single out k+%0d got=%b exp=%b", j, out_state[0], e_out); end
      total++; if (chan_done[0] !== e_done) begin bad++; $display("FAIL single chan_done k+%0d got=%b exp=%b", j, chan_done[0], e_done); end
      total++; if (all_done !== e_done) begin bad++; $display("FAIL single all_done k+%0d got=%b exp=%b", j, all_done, e_done); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL single busy k+%0d got=%b exp=%b", j, busy, e_busy); end
    end
    cleanup();
    total++; if (chan_done !== 8'h00) begin bad++; $display("FAIL single done_clear got=%h exp=00", chan_done); end
  endtask

  task automatic test_train();
    logic [11:0] pat;
    logic        e_out;
    chan_en = 8'h04; rest_level = 8'h04; npulse = 8'd3; gap = 32'd3;
    set_ch(2, 32'd0, 32'd2);
    pat = 12'b001110011100;
    arm_and_fire();
    for (int j = 1; j <= 13; j++) begin
      tick();
      e_out = (j <= 12) ? pat[12-j] : 1'b1;
      total++; if (out_state[2] !== e_out) begin bad++; $display("FAIL train out k+%0d got=%b exp=%b", j, out_state[2], e_out); end
      total++; if (chan_done[2] !== (j == 13)) begin bad++; $display("FAIL train chan_done k+%0d got=%b exp=%b", j, chan_done[2], (j == 13)); end
    end
    cleanup();
    gap = 32'd0;
    arm_and_fire();
    for (int j = 1; j <= 7; j++) begin
      tick();
      e_out = (j == 7);
      total++; if (out_state[2] !== e_out) begin bad++; $display("FAIL train_g0 out k+%0d got=%b exp=%b", j, out_state[2], e_out); end
      total++; if (chan_done[2] !== (j == 7)) begin bad++; $display("FAIL train_g0 chan_done k+%0d got=%b exp=%b", j, chan_done[2], (j == 7)); end
    end
    cleanup();
  endtask

  task automatic test_multi_channel();
    logic [1:0] e_out, e_done;
    chan_en = 8'h03; rest_level = 8'h00; npulse = 8'd1; gap = 32'd0;
    set_ch(0, 32'd1, 32'd1);
    set_ch(1, 32'd10, 32'd4);
    arm_and_fire();
    for (int j = 1; j <= 16; j++) begin
      tick();
      e_out  = {(j >= 11 && j <= 14), (j == 2)};
      e_done = {(j >= 15), (j >= 3)};
      total++; if (out_state[1:0] !== e_out) begin bad++; $display("FAIL multi out k+%0d got=%b exp=%b", j, out_state[1:0], e_out); end
      total++; if (chan_done[1:0] !== e_done) begin bad++; $display("FAIL multi chan_done k+%0d got=%b exp=%b", j, chan_done[1:0], e_done); end
      total++; if (all_done !== (j >= 15)) begin bad++; $display("FAIL multi all_done k+%0d got=%b exp=%b", j, all_done, (j >= 15)); end
    end
    cleanup();
  endtask

  task automatic test_abort();
    chan_en = 8'h01; rest_level = 8'h00; npulse = 8'd1; gap = 32'd0;
    set_ch(0, 32'd3, 32'd5);
    arm_and_fire();
    for (int j = 1; j <= 5; j++) tick();
    total++; if (out_state[0] !== 1'b1) begin bad++; $display("FAIL abort pre out got=%b exp=1", out_state[0]); end
    hard_stop = 1'b1; arm = 1'b0;
    tick();
    hard_stop = 1'b0;
    total++; if (out_state[0] !== 1'b0) begin bad++; $display("FAIL abort out got=%b exp=0", out_state[0]); end
    total++; if (chan_done !== 8'h00) begin bad++; $display("FAIL abort chan_done got=%h exp=00", chan_done); end
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort aborted got=%b exp=1", aborted); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy got=%b exp=0", busy); end
    tick(); tick();
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort sticky got=%b exp=1", aborted); end
    arm = 1'b1;
    tick();
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort rearm_clear got=%b exp=0", aborted); end
    cleanup();
  endtask

  task automatic test_edge_cases();
    chan_en = 8'h01; rest_level = 8'h00; gap = 32'd0;
    // W=0: completes at k+D+1 with no pulse
    npulse = 8'd1;
    set_ch(0, 32'd2, 32'd0);
    arm_and_fire();
    for (int j = 1; j <= 4; j++) begin
      tick();
      total++; if (out_state[0] !== 1'b0) begin bad++; $display("FAIL w0 out k+%0d got=%b exp=0", j, out_state[0]); end
      total++; if (chan_done[0] !== (j >= 3)) begin bad++; $display("FAIL w0 chan_done k+%0d got=%b exp=%b", j, chan_done[0], (j >= 3)); end
    end
    cleanup();
    // N=0 behaves as a single pulse
    npulse = 8'd0;
    set_ch(0, 32'd0, 32'd2);
    arm_and_fire();
    for (int j = 1; j <= 4; j++) begin
      tick();
      total++; if (out_state[0] !== (j <= 2)) begin bad++; $display("FAIL n0 out k+%0d got=%b exp=%b", j, out_state[0], (j <= 2)); end
      total++; if (chan_done[0] !== (j >= 3)) begin bad++; $display("FAIL n0 chan_done k+%0d got=%b exp=%b", j, chan_done[0], (j >= 3)); end
    end
    cleanup();
    // fire without arm
    chan_en = 8'hFF; npulse = 8'd1;
    fire = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    fire = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL noarm busy got=%b exp=0", busy); end
    total++; if (out_state !== 8'h00) begin bad++; $display("FAIL noarm out got=%h exp=00", out_state); end
    total++; if (chan_done !== 8'h00) begin bad++; $display("FAIL noarm chan_done got=%h exp=00", chan_done); end
    // arm and fire together: arms first edge, starts second
    chan_en = 8'h01;
    set_ch(0, 32'd0, 32'd1);
    arm = 1'b1; fire = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL armfire edge1 busy got=%b exp=0", busy); end
    tick();
    fire = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL armfire edge2 busy got=%b exp=1", busy); end
    tick();
    total++; if (out_state[0] !== 1'b1) begin bad++; $display("FAIL armfire out got=%b exp=1", out_state[0]); end
    tick();
    total++; if (out_state[0] !== 1'b0) begin bad++; $display("FAIL armfire out_end got=%b exp=0", out_state[0]); end
    total++; if (chan_done[0] !== 1'b1) begin bad++; $display("FAIL armfire chan_done got=%b exp=1", chan_done[0]); end
    cleanup();
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_train();
    test_multi_channel();
    test_abort();
    test_edge_cases();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
